// File: rtl/decode_stage_p.sv
// decode_stage_p: MIPS-style instruction decode stage with register file,
// write-through bypass, load-use hazard detection and ID/EX register.
module decode_stage_p #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       instr,
  input  logic [1:0]        ext_mode,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              id_valid,
  output logic [5:0]        id_opcode,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  output logic [DATA_W-1:0] id_imm,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd
);

  typedef struct packed {
    logic              valid;
    logic [5:0]        opcode;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
  } id_ex_t;

  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [AW-1:0]     rs_a;
  logic [AW-1:0]     rt_a;
  logic              wb_live;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm_x;
  logic [DATA_W-1:0] regs [NREGS];
  id_ex_t            d;
  id_ex_t            q;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm    = instr[15:0];
  assign rs_a   = rs[AW-1:0];
  assign rt_a   = rt[AW-1:0];

  assign wb_live = wb_we && (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Same-cycle writeback is forwarded so no WB->ID hazard exists
  always_comb begin
    rs_val = regs[rs_a];
    rt_val = regs[rt_a];
    if (wb_live && wb_addr == rs_a) rs_val = wb_data;
    if (wb_live && wb_addr == rt_a) rt_val = wb_data;
    if (rs_a == '0) rs_val = '0;
    if (rt_a == '0) rt_val = '0;
  end

  always_comb begin
    imm_x = DATA_W'($signed(imm));
    unique case (ext_mode)
      2'b01:   imm_x = DATA_W'(imm);
      2'b10:   imm_x = DATA_W'($signed({imm, 16'h0}));
      default: imm_x = DATA_W'($signed(imm));
    endcase
  end

  assign stall = if_valid && ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == rs) || (ex_rt == rt)) && !flush;

  always_comb begin
    d         = '0;
    d.valid   = if_valid && !stall && !flush;
    d.opcode  = opcode;
    d.rs_data = rs_val;
    d.rt_data = rt_val;
    d.imm     = imm_x;
    d.rs      = rs;
    d.rt      = rt;
    d.rd      = rd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

  assign id_valid   = q.valid;
  assign id_opcode  = q.opcode;
  assign id_rs_data = q.rs_data;
  assign id_rt_data = q.rt_data;
  assign id_imm     = q.imm;
  assign id_rs      = q.rs;
  assign id_rt      = q.rt;
  assign id_rd      = q.rd;

endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed vector table plus randomized run
// against a behavioural model of decode_stage_p.
module tb_decode_stage_p;

  localparam int DW = 32;
  localparam int NR = 32;

  typedef struct {
    bit          rstn;
    bit          ifv;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [1:0]  mode;
    bit          flush;
    bit          emr;
    logic [4:0]  ert;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          e_stall;
    bit          e_valid;
    logic [31:0] e_rsd;
    logic [31:0] e_rtd;
    logic [31:0] e_imm;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          if_valid;
  logic [31:0]   instr;
  logic [1:0]    ext_mode;
  logic          flush;
  logic          ex_mem_read;
  logic [4:0]    ex_rt;
  logic          wb_we;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          stall;
  logic          id_valid;
  logic [5:0]    id_opcode;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic [4:0]    id_rd;

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned mregs [NR];
  bit              m_stall;
  bit              m_valid;
  logic [DW-1:0]   m_rsd;
  logic [DW-1:0]   m_rtd;
  logic [DW-1:0]   m_imm;
  logic [5:0]      m_op;
  logic [4:0]      m_rs;
  logic [4:0]      m_rt;
  logic [4:0]      m_rd;

  vec_t tv[$];

  decode_stage_p #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr),
    .ext_mode(ext_mode), .flush(flush), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst_n       = v.rstn;
    if_valid    = v.ifv;
    instr       = {v.op, v.rs, v.rt, v.imm};
    ext_mode    = v.mode;
    flush       = v.flush;
    ex_mem_read = v.emr;
    ex_rt       = v.ert;
    wb_we       = v.we;
    wb_addr     = v.wa;
    wb_data     = v.wd;
    #1;
  endtask

  function automatic longint unsigned read_model(input vec_t v,
                                                 input int spec);
    int idx;
    idx = spec % NR;
    if (idx == 0) return 0;
    if (v.we && int'(v.wa) == idx) return longint'(v.wd);
    return mregs[idx];
  endfunction

  task automatic predict(input vec_t v);
    longint      x;
    logic [63:0] t;
    int          im;
    im = int'(v.imm);
    case (v.mode)
      2'd1:    x = im;
      2'd2: begin
        x = longint'(im) * 65536;
        if (im >= 32768) x = x - 64'h1_0000_0000;
      end
      default: x = (im >= 32768) ? im - 65536 : im;
    endcase
    t = x;
    m_stall = v.ifv && v.emr && v.ert != 0 &&
              (v.ert == v.rs || v.ert == v.rt) && !v.flush;
    if (v.rstn) begin
      m_valid = v.ifv && !m_stall && !v.flush;
      m_rsd   = DW'(read_model(v, int'(v.rs)));
      m_rtd   = DW'(read_model(v, int'(v.rt)));
      m_imm   = t[DW-1:0];
      m_op    = v.op;
      m_rs    = v.rs;
      m_rt    = v.rt;
      m_rd    = v.imm[15:11];
    end else begin
      m_valid = 0;
      m_rsd   = '0;
      m_rtd   = '0;
      m_imm   = '0;
      m_op    = '0;
      m_rs    = '0;
      m_rt    = '0;
      m_rd    = '0;
    end
  endtask

  task automatic commit(input vec_t v);
    if (!v.rstn) begin
      for (int i = 0; i < NR; i++) mregs[i] = 0;
    end else if (v.we && v.wa != 0) begin
      mregs[v.wa] = longint'(v.wd);
    end
  endtask

  task automatic chk_fields(input string p, input bit rstn,
                            input vec_t v);
    chk({p, ".opcode"}, 64'(id_opcode), rstn ? 64'(v.op) : 64'h0);
    chk({p, ".rs"}, 64'(id_rs), rstn ? 64'(v.rs) : 64'h0);
    chk({p, ".rt"}, 64'(id_rt), rstn ? 64'(v.rt) : 64'h0);
    chk({p, ".rd"}, 64'(id_rd), rstn ? 64'(v.imm[15:11]) : 64'h0);
  endtask

  initial begin
    vec_t v;
    string p;
    rst_n = 0; if_valid = 0; instr = '0; ext_mode = '0; flush = 0;
    ex_mem_read = 0; ex_rt = '0; wb_we = 0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < NR; i++) mregs[i] = 0;

    // rstn ifv op rs rt imm mode flush emr ert we wa wd | stall valid rsd rtd imm
    tv.push_back('{0,0,6'h00,0,0,16'h0000,0, 0,0,0, 0,0,32'h0,
                   0,0,32'h0,32'h0,32'h0});
    tv.push_back('{1,0,6'h00,0,0,16'h0000,0, 0,0,0, 1,5,32'h12345678,
                   0,0,32'h0,32'h0,32'h0});
    tv.push_back('{1,1,6'h23,5,0,16'h8001,0, 0,0,0, 0,0,32'h0,
                   0,1,32'h12345678,32'h0,32'hFFFF8001});
    tv.push_back('{1,1,6'h08,0,7,16'h8001,1, 0,0,0, 1,7,32'hDEADBEEF,
                   0,1,32'h0,32'hDEADBEEF,32'h00008001});
    tv.push_back('{1,1,6'h0F,7,0,16'h8001,2, 0,0,0, 1,0,32'hFFFFFFFF,
                   0,1,32'hDEADBEEF,32'h0,32'h80010000});
    tv.push_back('{1,1,6'h2B,0,5,16'h8001,3, 0,0,0, 0,0,32'h0,
                   0,1,32'h0,32'h12345678,32'hFFFF8001});
    tv.push_back('{1,1,6'h00,3,1,16'h0010,0, 0,1,3, 0,0,32'h0,
                   1,0,32'h0,32'h0,32'h10});
    tv.push_back('{1,1,6'h00,3,1,16'h0010,0, 0,1,0, 0,0,32'h0,
                   0,1,32'h0,32'h0,32'h10});
    tv.push_back('{1,1,6'h00,3,1,16'h0010,0, 1,1,3, 0,0,32'h0,
                   0,0,32'h0,32'h0,32'h10});
    tv.push_back('{1,1,6'h23,0,5,16'hFFFF,1, 0,1,5, 0,0,32'h0,
                   1,0,32'h0,32'h12345678,32'h0000FFFF});
    tv.push_back('{1,0,6'h23,0,5,16'hFFFF,1, 0,1,5, 0,0,32'h0,
                   0,0,32'h0,32'h12345678,32'h0000FFFF});
    tv.push_back('{1,1,6'h23,0,5,16'h7FFF,0, 0,0,5, 0,0,32'h0,
                   0,1,32'h0,32'h12345678,32'h00007FFF});
    tv.push_back('{0,1,6'h23,5,5,16'h8001,0, 0,1,5, 1,5,32'hAAAA5555,
                   1,0,32'h0,32'h0,32'h0});
    tv.push_back('{1,1,6'h23,5,7,16'h1234,2, 0,0,0, 0,0,32'h0,
                   0,1,32'h0,32'h0,32'h12340000});

    foreach (tv[i]) begin
      v = tv[i];
      p = $sformatf("vec%0d", i);
      apply(v);
      predict(v);
      chk({p, ".stall"}, 64'(stall), 64'(v.e_stall));
      @(posedge clk);
      #1;
      chk({p, ".valid"}, 64'(id_valid), 64'(v.e_valid));
      chk({p, ".rs_data"}, 64'(id_rs_data), 64'(v.e_rsd));
      chk({p, ".rt_data"}, 64'(id_rt_data), 64'(v.e_rtd));
      chk({p, ".imm"}, 64'(id_imm), 64'(v.e_imm));
      chk_fields(p, v.rstn, v);
      commit(v);
    end

    for (int n = 0; n < 400; n++) begin
      v.rstn  = ($urandom_range(0, 24) != 0);
      v.ifv   = $urandom_range(0, 3) != 0;
      v.op    = 6'($urandom);
      v.rs    = 5'($urandom_range(0, 7));
      v.rt    = 5'($urandom_range(0, 7));
      v.imm   = 16'($urandom);
      v.mode  = 2'($urandom);
      v.flush = ($urandom_range(0, 7) == 0);
      v.emr   = $urandom_range(0, 1) != 0;
      v.ert   = 5'($urandom_range(0, 7));
      v.we    = $urandom_range(0, 1) != 0;
      v.wa    = ($urandom_range(0, 3) == 0) ? 5'($urandom) :
                5'($urandom_range(0, 7));
      v.wd    = $urandom;
      p = $sformatf("rnd%0d", n);
      apply(v);
      predict(v);
      chk({p, ".stall"}, 64'(stall), 64'(m_stall));
      @(posedge clk);
      #1;
      chk({p, ".valid"}, 64'(id_valid), 64'(m_valid));
      chk({p, ".rs_data"}, 64'(id_rs_data), 64'(m_rsd));
      chk({p, ".rt_data"}, 64'(id_rt_data), 64'(m_rtd));
      chk({p, ".imm"}, 64'(id_imm), 64'(m_imm));
      chk({p, ".opcode"}, 64'(id_opcode), 64'(m_op));
      chk({p, ".rs"}, 64'(id_rs), 64'(m_rs));
      chk({p, ".rt"}, 64'(id_rt), 64'(m_rt));
      chk({p, ".rd"}, 64'(id_rd), 64'(m_rd));
      commit(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
